// File: rtl/vexriscv_axil_pkg.sv
// Shared constants and helpers for the AXI4-Lite register slave.
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   DATA_W / STRB_W         : data bus and byte-strobe widths
//   strb_merge()            : byte-lane merge of new data into an old word
//   idx_in_range()          : word-index bounds test
package vexriscv_axil_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [DATA_W-1:0] strb_merge(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return merged;
  endfunction

  function automatic logic idx_in_range(input int idx, input int num_words);
    return (idx >= 0) && (idx < num_words);
  endfunction

endpackage

// File: rtl/vexriscv_axil_regfile.sv
// Word storage for the AXI4-Lite register slave.
//   clk, rst_n : clock, asynchronous active-low reset (clears every word)
//   wr_en      : write strobe, one word per cycle
//   wr_idx     : word index to write (indices with no storage are ignored)
//   wr_data    : write data
//   wr_strb    : byte enables for wr_data
//   rd_idx     : word index for the asynchronous read port
//   rd_data    : current contents of rd_idx (0 for indices with no storage)
module vexriscv_axil_regfile
  import vexriscv_axil_pkg::*;
#(
  parameter int NUM_WORDS = 12,
  parameter int IDX_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [NUM_WORDS];

  // Index compare per word rather than direct array indexing keeps the
  // decode well defined when NUM_WORDS is not a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (wr_idx == IDX_W'(i)) mem[i] <= strb_merge(mem[i], wr_data, wr_strb);
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_data = mem[i];
    end
  end

endmodule

// File: rtl/vexriscv_axil_slave_regs.sv
// AXI4-Lite slave backed by a byte-writable register file.
//   ACLK, ARESETN      : clock, asynchronous active-low reset
//   S_AXI_AW*          : write address channel (AWPROT ignored)
//   S_AXI_W*           : write data channel with byte strobes
//   S_AXI_B*           : write response, SLVERR for out-of-range words
//   S_AXI_AR*          : read address channel (ARPROT ignored)
//   S_AXI_R*           : read data, RDATA=0 and SLVERR for out-of-range words
// One outstanding transaction per direction; read and write are independent.
module vexriscv_axil_slave_regs
  import vexriscv_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_WORDS          = 12
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

  // Protection bits and byte offsets carry no meaning for a word register file.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // ---------------- write channel ----------------
  logic              aw_held;
  logic              w_held;
  logic [IDX_W-1:0]  aw_idx;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;

  logic              aw_hs;
  logic              w_hs;
  logic              commit;
  logic [IDX_W-1:0]  cur_idx;
  logic [DATA_W-1:0] cur_data;
  logic [STRB_W-1:0] cur_strb;
  logic              wr_in_range;
  logic              wr_en;

  // READYs decode registered state only.
  assign S_AXI_AWREADY = !aw_held && !S_AXI_BVALID;
  assign S_AXI_WREADY  = !w_held && !S_AXI_BVALID;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;

  // Commit as soon as both halves are available, either from the holding
  // registers or from a handshake happening on this very edge.
  assign commit = (aw_held || aw_hs) && (w_held || w_hs);

  assign cur_idx  = aw_held ? aw_idx : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign cur_data = w_held  ? w_data : S_AXI_WDATA;
  assign cur_strb = w_held  ? w_strb : S_AXI_WSTRB;

  assign wr_in_range = idx_in_range(int'(cur_idx), NUM_WORDS);
  assign wr_en       = commit && wr_in_range;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_idx       <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
    end else begin
      if (aw_hs) aw_idx <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      if (w_hs) begin
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end

      // commit implies BVALID is low, since both READYs are gated by it.
      if (commit) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) aw_held <= 1'b1;
        if (w_hs)  w_held  <= 1'b1;
        if (S_AXI_BVALID && S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
      end
    end
  end

  // ---------------- read channel ----------------
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_word;
  logic              rd_in_range;
  logic              ar_hs;

  assign S_AXI_ARREADY = !S_AXI_RVALID;
  assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;
  assign rd_idx        = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_in_range   = idx_in_range(int'(rd_idx), NUM_WORDS);

  // rd_word is the pre-edge contents, so a read racing a same-word commit
  // returns the old value.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else if (ar_hs) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA  <= rd_in_range ? rd_word : '0;
      S_AXI_RRESP  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (S_AXI_RVALID && S_AXI_RREADY) begin
      S_AXI_RVALID <= 1'b0;
    end
  end

  // ---------------- storage ----------------
  vexriscv_axil_regfile #(
    .NUM_WORDS (NUM_WORDS),
    .IDX_W     (IDX_W)
  ) u_regfile (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .wr_en   (wr_en),
    .wr_idx  (cur_idx),
    .wr_data (cur_data),
    .wr_strb (cur_strb),
    .rd_idx  (rd_idx),
    .rd_data (rd_word)
  );

endmodule

// File: tb/tb_vexriscv_axil_slave_regs.sv
module tb_vexriscv_axil_slave_regs;

  localparam int NUM_WORDS = 12;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [5:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [5:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;

  vexriscv_axil_slave_regs #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (6),
    .NUM_WORDS          (NUM_WORDS)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  int n_pass   = 0;
  int n_checks = 0;

  // Reference memory: what each word should hold after all completed writes.
  logic [31:0] model [NUM_WORDS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic int word_of(input logic [5:0] addr);
    return int'(addr) / 4;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_WORDS; i++) model[i] = 32'h0;
  endtask

  // Write with independent AW/W start delays; the response is held off for
  // b_stall cycles before BREADY is raised.
  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_stall);
    bit aw_done = 0;
    bit w_done  = 0;
    bit aw_f, w_f;
    int cyc = 0;
    int idx;
    logic [1:0] exp_resp;
    idx = word_of(addr);
    exp_resp = (idx < NUM_WORDS) ? 2'b00 : 2'b10;
    S_AXI_BREADY = 1'b0;
    while (!(aw_done && w_done) && cyc < 50) begin
      S_AXI_AWADDR  = addr;
      S_AXI_WDATA   = data;
      S_AXI_WSTRB   = strb;
      S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
      S_AXI_WVALID  = !w_done && (cyc >= w_dly);
      aw_f = S_AXI_AWVALID && S_AXI_AWREADY;
      w_f  = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      if (aw_f) aw_done = 1;
      if (w_f)  w_done = 1;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      if (aw_done && !w_done) chk("awready_while_held", 32'(S_AXI_AWREADY), 0);
      if (w_done && !aw_done) chk("wready_while_held", 32'(S_AXI_WREADY), 0);
      cyc++;
    end
    chk("write_accepted", {30'd0, aw_done, w_done}, 3);
    if (idx < NUM_WORDS) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
    end
    chk("bvalid_after_commit", 32'(S_AXI_BVALID), 1);
    chk("bresp", 32'(S_AXI_BRESP), 32'(exp_resp));
    for (int s = 0; s < b_stall; s++) begin
      tick();
      chk("bvalid_stall", 32'(S_AXI_BVALID), 1);
      chk("bresp_stall", 32'(S_AXI_BRESP), 32'(exp_resp));
      chk("awready_stall", 32'(S_AXI_AWREADY), 0);
      chk("wready_stall", 32'(S_AXI_WREADY), 0);
    end
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    chk("bvalid_cleared", 32'(S_AXI_BVALID), 0);
    chk("awready_after_b", 32'(S_AXI_AWREADY), 1);
    chk("wready_after_b", 32'(S_AXI_WREADY), 1);
  endtask

  task automatic axi_read(input logic [5:0] addr, input int r_stall, output logic [31:0] data);
    int idx;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    idx = word_of(addr);
    if (idx < NUM_WORDS) begin
      exp_d = model[idx];
      exp_r = 2'b00;
    end else begin
      exp_d = 32'h0;
      exp_r = 2'b10;
    end
    chk("arready_idle", 32'(S_AXI_ARREADY), 1);
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    chk("rvalid", 32'(S_AXI_RVALID), 1);
    chk("rdata", S_AXI_RDATA, exp_d);
    chk("rresp", 32'(S_AXI_RRESP), 32'(exp_r));
    data = S_AXI_RDATA;
    for (int s = 0; s < r_stall; s++) begin
      tick();
      chk("rvalid_stall", 32'(S_AXI_RVALID), 1);
      chk("rdata_stall", S_AXI_RDATA, exp_d);
      chk("rresp_stall", 32'(S_AXI_RRESP), 32'(exp_r));
      chk("arready_stall", 32'(S_AXI_ARREADY), 0);
    end
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
    chk("rvalid_cleared", 32'(S_AXI_RVALID), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] old_word;
    int hs_count;

    ARESETN       = 1'b0;
    S_AXI_AWADDR  = '0;
    S_AXI_AWPROT  = 3'b000;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA   = '0;
    S_AXI_WSTRB   = '0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b0;
    S_AXI_ARADDR  = '0;
    S_AXI_ARPROT  = 3'b000;
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b0;
    model_clear();

    repeat (3) @(posedge ACLK);
    #1;
    chk("reset_bvalid", 32'(S_AXI_BVALID), 0);
    chk("reset_rvalid", 32'(S_AXI_RVALID), 0);
    chk("reset_bresp", 32'(S_AXI_BRESP), 0);
    chk("reset_rresp", 32'(S_AXI_RRESP), 0);
    chk("reset_rdata", S_AXI_RDATA, 0);
    ARESETN = 1'b1;
    tick();
    chk("ready_after_reset", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 7);

    // Every word reads zero after reset; the first word past the end errors.
    for (int i = 0; i < NUM_WORDS; i++) axi_read(6'(i * 4), 0, rd);
    axi_read(6'h30, 0, rd);
    chk("oor_read_data", rd, 0);

    // Same-cycle AW/W.
    axi_write(6'h0C, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    axi_read(6'h0C, 0, rd);
    chk("deadbeef_readback", rd, 32'hDEADBEEF);

    // AW leads W by 3 cycles, then W leads AW by 2.
    axi_write(6'h04, 32'hCAFE0001, 4'hF, 0, 3, 0);
    axi_write(6'h14, 32'h5A5A1234, 4'hF, 2, 0, 0);
    repeat (2) begin
      tick();
      chk("no_extra_b", 32'(S_AXI_BVALID), 0);
    end
    axi_read(6'h04, 0, rd);
    axi_read(6'h14, 0, rd);

    // Partial strobes.
    axi_write(6'h08, 32'h11223344, 4'hF, 0, 0, 0);
    axi_write(6'h08, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
    axi_read(6'h08, 0, rd);
    chk("strobe_merge", rd, 32'h11BB33DD);

    // Out-of-range write: SLVERR, nothing stored.
    axi_write(6'h3C, 32'hFFFFFFFF, 4'hF, 1, 0, 0);

    // Backpressure on both response channels.
    axi_write(6'h18, 32'h0BADF00D, 4'hF, 0, 0, 5);
    axi_read(6'h18, 5, rd);
    axi_read(6'h34, 5, rd);

    // Read and write of the same word on the commit edge: read sees old data.
    old_word = model[3];
    S_AXI_AWADDR  = 6'h0C;
    S_AXI_WDATA   = 32'h01020304;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_ARADDR  = 6'h0C;
    S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_ARVALID = 1'b0;
    model[3] = 32'h01020304;
    chk("race_bvalid", 32'(S_AXI_BVALID), 1);
    chk("race_rvalid", 32'(S_AXI_RVALID), 1);
    chk("race_rdata_old", S_AXI_RDATA, old_word);
    S_AXI_BREADY = 1'b1;
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    S_AXI_RREADY = 1'b0;
    axi_read(6'h0C, 0, rd);

    // Back-to-back reads with RREADY high: one accept every other cycle.
    hs_count = 0;
    S_AXI_RREADY  = 1'b1;
    S_AXI_ARADDR  = 6'h08;
    S_AXI_ARVALID = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (S_AXI_ARREADY) hs_count++;
      tick();
    end
    S_AXI_ARVALID = 1'b0;
    tick();
    S_AXI_RREADY = 1'b0;
    chk("read_throughput", hs_count, 4);
    chk("read_idle_after_burst", 32'(S_AXI_RVALID), 0);

    // Randomized traffic against the model.
    for (int t = 0; t < 30; t++) begin
      axi_write(6'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      axi_read(6'($urandom_range(0, 63)), $urandom_range(0, 2), rd);
    end
    for (int i = 0; i < NUM_WORDS; i++) axi_read(6'(i * 4), 0, rd);

    // Reset with AW held and no W: no response, storage cleared.
    axi_write(6'h04, 32'h77665544, 4'hF, 0, 0, 0);
    S_AXI_AWADDR  = 6'h04;
    S_AXI_AWVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    chk("aw_held_before_reset", 32'(S_AXI_AWREADY), 0);
    tick();
    ARESETN = 1'b0;
    #2;
    chk("reset_mid_bvalid", 32'(S_AXI_BVALID), 0);
    chk("reset_mid_rvalid", 32'(S_AXI_RVALID), 0);
    model_clear();
    tick();
    ARESETN = 1'b1;
    tick();
    chk("awready_after_mid_reset", 32'(S_AXI_AWREADY), 1);
    chk("wready_after_mid_reset", 32'(S_AXI_WREADY), 1);
    repeat (3) begin
      tick();
      chk("no_b_after_reset", 32'(S_AXI_BVALID), 0);
    end
    axi_read(6'h04, 0, rd);
    chk("word_cleared_by_reset", rd, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vexriscv_axil_slave_regs.md
# vexriscv_axil_slave_regs

AXI4-Lite slave (responder) backed by a small byte-writable register file; the completion end for the M00/M01 AXI4-Lite masters in the vexriscv IP and the synthesizable replacement for the VIP slave agents in the BFM design. Each write and read channel handles one transaction at a time. Out-of-range accesses complete with SLVERR so master-side error flags can be exercised.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 supported
- C_S_AXI_ADDR_WIDTH, 6, byte address width
- NUM_WORDS, 12, implemented 32-bit words, 1..2^(C_S_AXI_ADDR_WIDTH-2)
- ACLK  in  1  single clock; all logic on rising edge
- ARESETN  in  1  asynchronous, active-low reset
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write byte address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake
- S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read byte address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  00 OKAY, 10 SLVERR
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake

## Operation
- Word index = addr[ADDR-1:2]; addr[1:0] ignored. Index >= NUM_WORDS is out of range.
- Write path state: aw_held, w_held, bvalid, with latched address, data, and strobe.
  - AWREADY = !aw_held && !bvalid.
  - WREADY = !w_held && !bvalid.
  - AW and W are accepted independently, in either order or in the same cycle.
- Commit edge: the first edge at which the address is held-or-handshaking and the data is held-or-handshaking.
  - In range: bytes with WSTRB=1 are updated; BRESP=OKAY.
  - Out of range: no update; BRESP=SLVERR.
  - Both held flags clear and BVALID goes to 1.
- BVALID, BRESP: stable until the BVALID&&BREADY edge, then BVALID=0.
- Read path:
  - ARREADY = !rvalid.
  - At the AR handshake edge, RDATA and RRESP are registered and RVALID goes to 1.
  - In range: RDATA = word contents before that edge, RRESP=OKAY.
  - Out of range: RDATA=0, RRESP=SLVERR.
- RVALID, RDATA, RRESP: stable until the RVALID&&RREADY edge, then RVALID=0.
- Read and write paths are fully independent. On a same-word read handshake at the commit edge, the read returns the old value.
- No READY depends combinationally on any VALID; all READYs decode registered state.

## Timing
- Reset (ARESETN=0, asynchronous):
  - all registers and held flags = 0;
  - BVALID=RVALID=0, BRESP=RRESP=00, RDATA=0.
- Reset release: AWREADY, WREADY, ARREADY are 1 from the first cycle after ARESETN deasserts.
- Write latency: AW and W in the same cycle N give BVALID=1 in cycle N+1. The next AW or W can be accepted in the cycle after the B handshake.
- Read latency: AR at cycle N gives RVALID=1 in cycle N+1. With RREADY held high, throughput is one read per 2 cycles.
- Reset mid-transaction: pending held data is discarded, VALIDs drop immediately, and register contents are cleared.

## Structure
- Package vexriscv_axil_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, data/strobe width constants.
- Sub-module vexriscv_axil_regfile holds the storage:
  - NUM_WORDS x 32 with byte-strobe write port and asynchronous read port;
  - reset clears all words.
- Top level holds the write and read channel state.

## Test plan
- After reset, read all words 0..NUM_WORDS-1 -> RDATA=0, RRESP=OKAY. Read at 0x30 -> RDATA=0, RRESP=SLVERR.
- Write 0x0C, data 0xDEADBEEF, WSTRB=4'hF, AW and W same cycle -> BVALID the next cycle with BRESP=OKAY. A read of 0x0C returns 0xDEADBEEF.
- AW at 0x04 issued 3 cycles before W, then a second write with W before AW -> each completes exactly once with correct data. AWREADY/WREADY are low while held or while BVALID=1.
- Partial strobes:
  - first write 0x08 = 0x11223344 with WSTRB=4'hF;
  - then write 0xAABBCCDD with WSTRB=4'b0101;
  - read 0x08 -> 0x11BB33DD.
- Hold BREADY=0 for 5 cycles and RREADY=0 for 5 cycles -> BVALID/BRESP and RVALID/RDATA/RRESP are held stable, and AWREADY, WREADY, ARREADY stay 0.
- Assert ARESETN=0 mid-write (AW held, W not yet sent) -> AWREADY returns 1 after release, no B response is issued, and word reads back 0.
